// File: rtl/uart_tx_queue.sv
// Byte-queued UART transmitter: FIFO_DEPTH-entry queue feeding an 8N1 serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high; pops the head byte as soon as the queue is non-empty
// START  | start bit (low) for CLK_DIV cycles
// DATA   | 8 data bits, LSB first, CLK_DIV cycles each
// PARITY | even parity of the byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (high); chains straight into START if more bytes wait

module uart_tx_queue #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_send,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       tx_overflow,
    output logic       uart_tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [15:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             uart_tx_q, uart_tx_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic       push;
    logic       pop;
    logic       q_empty;
    logic       bit_done;
    logic [7:0] head_byte;

    assign tx_full     = (count_q == FULL_CNT);
    assign q_empty     = (count_q == '0);
    assign tx_busy     = (state_q != IDLE) || !q_empty;
    assign tx_overflow = overflow_q;
    assign uart_tx     = uart_tx_q;
    assign bit_done    = (bit_cnt_q == 16'd0);
    assign head_byte   = fifo_mem_q[rd_ptr_q];

    // Queue bookkeeping; a write while full is dropped even if a pop frees a slot this cycle.
    always_comb begin
        push       = tx_send && !tx_full;
        overflow_d = overflow_q || (tx_send && tx_full);
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (!q_empty) begin
                    pop       = 1'b1;
                    state_d   = START;
                    bit_cnt_d = BIT_RELOAD;
                    shift_d   = head_byte;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^head_byte;
`endif
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_cnt_d = BIT_RELOAD;
                    bit_idx_d = 3'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    bit_cnt_d = BIT_RELOAD;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d   = STOP;
                    bit_cnt_d = BIT_RELOAD;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (!q_empty) begin
                        pop       = 1'b1;
                        state_d   = START;
                        bit_cnt_d = BIT_RELOAD;
                        shift_d   = head_byte;
`ifdef UART_TX_PARITY_EN
                        parity_d  = ^head_byte;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level registered from the next state so uart_tx is glitch-free.
        case (state_d)
            START:   uart_tx_d = 1'b0;
            DATA:    uart_tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  uart_tx_d = parity_d;
`endif
            default: uart_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            uart_tx_q  <= 1'b1;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            uart_tx_q  <= uart_tx_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_mem_q[wr_ptr_q] <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed frames plus random traffic,
// compared every cycle against a frame-level model (byte queue + frame timing).

module tb_uart_tx_queue;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_send = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_full;
    logic       tx_busy;
    logic       tx_overflow;
    logic       uart_tx;

    uart_tx_queue #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .tx_full     (tx_full),
        .tx_busy     (tx_busy),
        .tx_overflow (tx_overflow),
        .uart_tx     (uart_tx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: pending bytes, the frame on the line (bit list + first cycle), sticky overflow.
    logic [7:0] m_q[$];
    bit         m_active = 1'b0;
    int         m_fs = 0;
    logic       m_bits[NBITS];
    bit         m_ovf = 1'b0;
    int         n = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic load_frame(input logic [7:0] b);
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
        m_bits[9] = ^b;
`endif
        m_bits[NBITS-1] = 1'b1;
    endtask

    task automatic model_edge(input bit rst, input bit snd, input logic [7:0] d);
        bit last;
        bit full;
        int prev;
        prev = n;
        n++;
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_ovf = 1'b0;
            return;
        end
        full = (m_q.size() == DEPTH);
        last = m_active && (prev - m_fs == FRAME - 1);
        if (m_q.size() > 0 && (!m_active || last)) begin
            load_frame(m_q.pop_front());
            m_active = 1'b1;
            m_fs = n;
        end else if (last) begin
            m_active = 1'b0;
        end
        if (snd) begin
            if (full) m_ovf = 1'b1;
            else m_q.push_back(d);
        end
    endtask

    function automatic logic exp_tx();
        if (!m_active) return 1'b1;
        return m_bits[(n - m_fs) / CLK_DIV];
    endfunction

    task automatic cycle(input bit rst, input bit snd, input logic [7:0] d);
        reset = rst;
        tx_send = snd;
        tx_data = d;
        @(posedge clk);
        model_edge(rst, snd, d);
        #1;
        check("uart_tx", uart_tx, exp_tx());
        check("tx_busy", tx_busy, (m_active || m_q.size() > 0));
        check("tx_full", tx_full, (m_q.size() == DEPTH));
        check("tx_overflow", tx_overflow, m_ovf);
        reset = 1'b0;
        tx_send = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) cycle(0, 0, 8'h00);
    endtask

    int busy_len;

    initial begin
        cycle(1, 1, 8'hAA);
        cycle(1, 0, 8'h00);
        check("reset_line", uart_tx, 1'b1);
        check("reset_busy", tx_busy, 1'b0);

        // Single byte 0x55: busy from the write through the last stop cycle.
        cycle(0, 1, 8'h55);
        busy_len = 0;
        for (int i = 0; i < FRAME + 10; i++) begin
            if (tx_busy) busy_len++;
            cycle(0, 0, 8'h00);
        end
        check("busy_len_1", busy_len, FRAME + 1);

        // Two bytes back to back with no idle gap between frames.
        cycle(0, 1, 8'hA3);
        busy_len = 0;
        if (tx_busy) busy_len++;
        cycle(0, 1, 8'h0F);
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            if (tx_busy) busy_len++;
            cycle(0, 0, 8'h00);
        end
        check("busy_len_2", busy_len, 2 * FRAME + 1);

`ifdef UART_TX_PARITY_EN
        cycle(0, 1, 8'h07);
        idle(FRAME + 4);
        cycle(0, 1, 8'h03);
        idle(FRAME + 4);
`endif

        // Five writes fill the queue with nothing dropped; a sixth is dropped.
        for (int i = 1; i <= 5; i++) cycle(0, 1, 8'(i));
        check("fill_full", tx_full, 1'b1);
        check("fill_no_ovf", tx_overflow, 1'b0);
        cycle(0, 1, 8'h06);
        check("sixth_ovf", tx_overflow, 1'b1);
        idle(20);
        cycle(1, 0, 8'h00);

        // Write while full on the same cycle as the stop-bit pop.
        for (int i = 1; i <= 5; i++) cycle(0, 1, 8'(8'h10 + i));
        for (int i = 0; i < 200 && !(m_active && (n - m_fs == FRAME - 1)); i++) cycle(0, 0, 8'h00);
        check("pop_edge_found", (m_active && (n - m_fs == FRAME - 1)), 1'b1);
        cycle(0, 1, 8'hEE);
        check("pop_drop_ovf", tx_overflow, 1'b1);
        check("pop_drop_not_full", tx_full, 1'b0);
        idle(5 * FRAME);

        // Reset during data bit 3 of 0xFF with two more bytes queued.
        cycle(1, 0, 8'h00);
        cycle(0, 1, 8'hFF);
        cycle(0, 1, 8'h11);
        cycle(0, 1, 8'h22);
        idle(CLK_DIV * 4 + 1);
        cycle(1, 1, 8'h99);
        check("rst_mid_line", uart_tx, 1'b1);
        check("rst_mid_busy", tx_busy, 1'b0);
        check("rst_mid_full", tx_full, 1'b0);
        idle(3 * FRAME);

        // Random traffic with occasional resets and bursts.
        for (int i = 0; i < 4000; i++) begin
            bit r;
            bit s;
            r = ($urandom_range(0, 799) == 0);
            s = ((i / 500) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
            cycle(r, s, 8'($urandom));
        end
        idle(6 * FRAME);
        check("drained", tx_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning byte queue depth; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tx_send  input  1  single-cycle write strobe from the SoC bus.
REQ-006 SHALL have port tx_data  input  8  byte to transmit, sampled when tx_send=1.
REQ-007 SHALL have port tx_full  output  1  queue holds FIFO_DEPTH bytes.
REQ-008 SHALL have port tx_busy  output  1  frame in progress or queue non-empty.
REQ-009 SHALL have port tx_overflow  output  1  sticky: a write was dropped.
REQ-010 SHALL have port uart_tx  output  1  serial line, idle high.

Function
REQ-011 SHALL write tx_data into the queue on any cycle with tx_send=1 and tx_full=0.
REQ-012 SHALL drop the write and set tx_overflow when tx_send=1 and tx_full=1, even if a pop occurs that same cycle; tx_overflow clears only on reset.
REQ-013 SHALL derive tx_full from the registered occupancy count, with read/write pointers wrapping modulo FIFO_DEPTH.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 SHALL move IDLE->START by popping the head byte in any IDLE cycle with a non-empty queue; uart_tx goes low the cycle after the pop.
REQ-016 SHALL hold each bit on uart_tx for exactly CLK_DIV cycles, timed by a down-counter reloaded at every bit boundary.
REQ-017 SHALL send 8 data bits LSB first in DATA, tracked by a 3-bit index that terminates at 7.
REQ-018 SHALL drive uart_tx=1 in STOP for CLK_DIV cycles, then go START directly if the queue is non-empty (no idle gap), else IDLE.
REQ-019 SHALL allow a write and a pop in the same cycle with occupancy unchanged.
REQ-020 SHALL keep uart_tx high in IDLE; tx_busy=0 only in IDLE with an empty queue.
REQ-021 SHALL produce a frame of 10*CLK_DIV cycles without the macro, 11*CLK_DIV with it.

Reset
REQ-022 SHALL, on reset=1 at a clock edge, force IDLE, empty the queue, zero counters, and drive uart_tx=1, tx_full=0, tx_busy=0, tx_overflow=0 from the next cycle.
REQ-023 SHALL abort any frame in progress when reset occurs mid-frame, returning the line high with no further bits.
REQ-024 SHALL ignore tx_send during a reset cycle.

Configuration
REQ-025 SHALL, when UART_TX_PARITY_EN is defined, insert a PARITY state between DATA and STOP, driving even parity (XOR of the 8 data bits) for CLK_DIV cycles.
REQ-026 SHALL, when UART_TX_PARITY_EN is undefined, contain no PARITY state or logic and go DATA->STOP directly.

Verification
REQ-027 SHALL verify: CLK_DIV=4, reset released, tx_send with 0x55 -> uart_tx low cycles 1-4, then 1,0,1,0,1,0,1,0 in 4-cycle bits, high stop, tx_busy low after cycle 40.
REQ-028 SHALL verify: 5 writes 0x01..0x05 on consecutive cycles, FIFO_DEPTH=4 -> first pops at once, remaining 4 fill the queue, nothing dropped, tx_overflow=0; a 6th write while tx_full=1 -> dropped, tx_overflow=1.
REQ-029 SHALL verify: two queued bytes 0xA3, 0x0F -> second start bit begins on the cycle after the first stop bit's 4th cycle; total 80 cycles busy.
REQ-030 SHALL verify: with UART_TX_PARITY_EN, byte 0x07 -> parity bit 1 for 4 cycles; byte 0x03 -> parity bit 0; frame length 44 cycles.
REQ-031 SHALL verify: reset asserted during bit 3 of 0xFF with 2 bytes queued -> uart_tx=1, tx_busy=0, tx_full=0 the next cycle; no further frames.
REQ-032 SHALL verify: write while full and pop in same cycle -> write dropped, overflow set, occupancy decremented by one.
